// File: rtl/window_gen_3x3_if.sv
// Pixel-ingest and window-issue signals of the 3x3 window generator.
// The generator uses the master modport; the ingest stage and edge core use the slave side.
interface window_gen_3x3_if #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int PIXEL_W    = 4
);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic [PIXEL_W-1:0]            pixelIn;
    logic                          pixelInSof;
    logic                          pixelInValid;
    logic                          pixelInReady;
    logic [2:0][2:0][PIXEL_W-1:0]  window;
    logic                          windowValid;
    logic [ROW_W-1:0]              windowRow;
    logic [COL_W-1:0]              windowCol;
    logic                          edgeDone;
    logic                          frameDone;

    modport master (
        input  pixelIn, pixelInSof, pixelInValid, edgeDone,
        output pixelInReady, window, windowValid, windowRow, windowCol, frameDone
    );

    modport slave (
        output pixelIn, pixelInSof, pixelInValid, edgeDone,
        input  pixelInReady, window, windowValid, windowRow, windowCol, frameDone
    );
endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator: two line buffers feed a shift window, and one
// interior window at a time is held for the edge core until it reports completion.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int PIXEL_W    = 4
) (
    input  logic              clk,
    input  logic              nreset,
    window_gen_3x3_if.master  bus
);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {
        ACCEPT,
        SHIFT,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic [PIXEL_W-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_W-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_W-1:0] pix_q;
    logic [PIXEL_W-1:0] top_q;
    logic [PIXEL_W-1:0] mid_q;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               last_q;
    logic               accept;
    logic [COL_W-1:0]   rd_col;

    assign accept = bus.pixelInValid && bus.pixelInReady;
    // A start-of-frame pixel always lands in column 0, whatever the counter says.
    assign rd_col = bus.pixelInSof ? '0 : col;

    // NOTE: line buffers and their read registers have no reset; stale contents
    // never reach a valid window because no window is issued before row 2 / col 2.
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_q <= bus.pixelIn;
            top_q <= lb1[rd_col];
            mid_q <= lb0[rd_col];
        end
        if (state == SHIFT) begin
            lb0[col] <= pix_q;
            lb1[col] <= mid_q;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the values from the start of the cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state            <= ACCEPT;
            bus.pixelInReady <= 1'b1;
            bus.window       <= '0;
            bus.windowValid  <= 1'b0;
            bus.windowRow    <= '0;
            bus.windowCol    <= '0;
            bus.frameDone    <= 1'b0;
            row              <= '0;
            col              <= '0;
            last_q           <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each set below lasts one cycle.
            bus.windowValid <= 1'b0;
            bus.frameDone   <= 1'b0;

            unique case (state)
                ACCEPT: begin
                    if (accept) begin
                        bus.pixelInReady <= 1'b0;
                        state            <= SHIFT;
                        if (bus.pixelInSof) begin
                            row <= '0;
                            col <= '0;
                        end
                    end
                end

                SHIFT: begin
                    for (int i = 0; i < 3; i++) begin
                        bus.window[i][0] <= bus.window[i][1];
                        bus.window[i][1] <= bus.window[i][2];
                    end
                    bus.window[0][2] <= top_q;
                    bus.window[1][2] <= mid_q;
                    bus.window[2][2] <= pix_q;

                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end

                    if (row >= ROW_W'(2) && col >= COL_W'(2)) begin
                        bus.windowRow   <= row - ROW_W'(1);
                        bus.windowCol   <= col - COL_W'(1);
                        last_q          <= (row == ROW_LAST) && (col == COL_LAST);
                        bus.windowValid <= 1'b1;
                        state           <= ISSUE;
                    end else begin
                        bus.pixelInReady <= 1'b1;
                        state            <= ACCEPT;
                    end
                end

                ISSUE: begin
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (bus.edgeDone) begin
                        bus.pixelInReady <= 1'b1;
                        bus.frameDone    <= last_q;
                        state            <= ACCEPT;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomized bench for window_gen_3x3: a frame-image reference model predicts every
// window, an edge-core responder acknowledges each one, and outputs are checked on negedges.
module tb_window_gen_3x3;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 4;
    localparam int NPIX = W * H;

    typedef logic [2:0][2:0][PW-1:0] win_t;

    typedef struct {
        win_t w;
        int   row;
        int   col;
        bit   last;
        int   acc_cyc;
    } exp_t;

    logic clk;
    logic nreset;

    window_gen_3x3_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) bus ();

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int       cyc = 0;
    exp_t     q[$];
    logic [PW-1:0] img [H][W];
    int       m_idx = 0;
    int       frames_exp = 0;
    int       frames_seen = 0;
    int       spurious_fd = 0;
    win_t     dut_wins[$];
    int       dut_rows[$];
    int       dut_cols[$];
    logic [PW-1:0] frame_px [NPIX];

    int       wait_cnt = 0;
    bit       after_done = 0;
    int       hold_bad = 0;
    win_t     held;
    exp_t     cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic finish_bench();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    function automatic win_t mk_win(input int a, b, c, d, e, f, g, h, k);
        win_t w;
        w[0][0] = PW'(a); w[0][1] = PW'(b); w[0][2] = PW'(c);
        w[1][0] = PW'(d); w[1][1] = PW'(e); w[1][2] = PW'(f);
        w[2][0] = PW'(g); w[2][1] = PW'(h); w[2][2] = PW'(k);
        return w;
    endfunction

    // Reference model: place the pixel into the frame image by raster index and
    // predict the window centred one row up and one column left of it.
    function automatic void model_accept(input logic [PW-1:0] p, input bit sof);
        int   r;
        int   c;
        exp_t e;
        if (sof) m_idx = 0;
        r = m_idx / W;
        c = m_idx % W;
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[i][j] = img[r - 2 + i][c - 2 + j];
            e.row     = r - 1;
            e.col     = c - 1;
            e.last    = (m_idx == NPIX - 1);
            e.acc_cyc = cyc;
            q.push_back(e);
            if (e.last) frames_exp++;
        end
        m_idx = (m_idx + 1) % NPIX;
    endfunction

    // Ingest driver: valid stays high while the DUT back-pressures; random idle gaps.
    task automatic send_pixel(input logic [PW-1:0] p, input bit sof);
        int n;
        if ($urandom_range(0, 3) == 0) begin
            bus.pixelInValid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        bus.pixelIn      = p;
        bus.pixelInSof   = sof;
        bus.pixelInValid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.pixelInReady) break;
            n++;
            if (n > 100) begin
                check("ready_timeout", 64'(n), 64'(0));
                finish_bench();
            end
        end
        model_accept(p, sof);
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int from, input int to, input bit sof_first);
        for (int k = from; k <= to; k++)
            send_pixel(frame_px[k], (k == from) && sof_first);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NPIX; k++) frame_px[k] = PW'($urandom);
    endtask

    task automatic drain();
        int n;
        bus.pixelInValid = 1'b0;
        bus.pixelInSof   = 1'b0;
        n = 0;
        while ((q.size() != 0 || wait_cnt != 0 || after_done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 64'(n < 400), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(bus.pixelInReady), 64'(1));
        check({tag, "_wvalid"}, 64'(bus.windowValid),  64'(0));
        check({tag, "_window"}, 64'(bus.window),       64'(0));
        check({tag, "_wrow"},   64'(bus.windowRow),    64'(0));
        check({tag, "_wcol"},   64'(bus.windowCol),    64'(0));
        check({tag, "_fdone"},  64'(bus.frameDone),    64'(0));
    endtask

    // Edge-core responder and output monitor.
    initial begin
        bus.edgeDone = 1'b0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                wait_cnt     = 0;
                after_done   = 0;
                bus.edgeDone = 1'b0;
            end else begin
                bus.edgeDone = 1'b0;
                if (after_done) begin
                    check("ready_after_done", 64'(bus.pixelInReady), 64'(1));
                    check("frame_done", 64'(bus.frameDone), 64'(cur.last));
                    if (bus.frameDone) frames_seen++;
                    after_done = 0;
                end else if (bus.frameDone) begin
                    spurious_fd++;
                end

                if (wait_cnt > 0) begin
                    if (bus.window !== held || bus.windowValid !== 1'b0 ||
                        bus.pixelInReady !== 1'b0 || bus.frameDone !== 1'b0 ||
                        int'(bus.windowRow) != cur.row || int'(bus.windowCol) != cur.col)
                        hold_bad++;
                    if (wait_cnt == 5) begin
                        check("hold_stable", 64'(hold_bad), 64'(0));
                        bus.edgeDone = 1'b1;
                        wait_cnt     = 0;
                        after_done   = 1;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    if (bus.windowValid) begin
                        check("window_expected", 64'(q.size() != 0), 64'(1));
                        if (q.size() != 0) begin
                            cur = q.pop_front();
                            check("window", 64'(bus.window), 64'(cur.w));
                            check("window_row", 64'(bus.windowRow), 64'(cur.row));
                            check("window_col", 64'(bus.windowCol), 64'(cur.col));
                            check("latency", 64'(cyc - cur.acc_cyc), 64'(2));
                            check("ready_in_issue", 64'(bus.pixelInReady), 64'(0));
                            dut_wins.push_back(bus.window);
                            dut_rows.push_back(int'(bus.windowRow));
                            dut_cols.push_back(int'(bus.windowCol));
                            held     = bus.window;
                            hold_bad = 0;
                            wait_cnt = 1;
                        end
                    end
                    // Spurious completions in ACCEPT/SHIFT/ISSUE must be ignored.
                    bus.edgeDone = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int f0;
        int n;

        nreset           = 1'b0;
        bus.pixelIn      = '0;
        bus.pixelInSof   = 1'b0;
        bus.pixelInValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Directed pattern frame: pixel = (5r + c) mod 16.
        for (int k = 0; k < NPIX; k++) frame_px[k] = PW'(((k / W) * 5 + (k % W)) % 16);
        s0 = dut_wins.size();
        f0 = frames_exp;
        send_range(0, NPIX - 1, 1'b1);
        drain();
        check("pattern_win_count", 64'(dut_wins.size() - s0), 64'(6));
        check("pattern_frames", 64'(frames_seen), 64'(f0 + 1));
        if (dut_wins.size() >= s0 + 6) begin
            check("pattern_w0", 64'(dut_wins[s0]), 64'(mk_win(0, 1, 2, 5, 6, 7, 10, 11, 12)));
            check("pattern_w0_pos", 64'({dut_rows[s0], dut_cols[s0]}), 64'({32'd1, 32'd1}));
            check("pattern_w1", 64'(dut_wins[s0 + 1]), 64'(mk_win(1, 2, 3, 6, 7, 8, 11, 12, 13)));
            check("pattern_w1_col", 64'(dut_cols[s0 + 1]), 64'(2));
            check("pattern_w3", 64'(dut_wins[s0 + 3]), 64'(mk_win(5, 6, 7, 10, 11, 12, 15, 0, 1)));
            check("pattern_w3_pos", 64'({dut_rows[s0 + 3], dut_cols[s0 + 3]}), 64'({32'd2, 32'd1}));
        end

        // Random frame, SOF on the expected (0,0) pixel chosen at random.
        fill_random();
        send_range(0, NPIX - 1, 1'($urandom_range(0, 1)));
        drain();
        check("random_frames", 64'(frames_seen), 64'(frames_exp));

        // Mid-frame SOF at pixel (2,3): aborted frame gives no frameDone.
        fill_random();
        f0 = frames_seen;
        send_range(0, 2 * W + 2, 1'b0);
        fill_random();
        s0 = dut_wins.size();
        send_range(0, NPIX - 1, 1'b1);
        drain();
        check("sof_restart_frames", 64'(frames_seen), 64'(f0 + 1));
        check("sof_restart_win_count", 64'(dut_wins.size() - s0), 64'(7));

        // Reset while a window is waiting for completion.
        fill_random();
        send_range(0, 2 * W + 2, 1'($urandom_range(0, 1)));
        bus.pixelInValid = 1'b0;
        n = 0;
        while (wait_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait_done", 64'(n < 100), 64'(1));
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        q.delete();
        m_idx = 0;
        repeat (2) @(posedge clk);
        #3;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Two identical frames back to back after reset.
        fill_random();
        f0 = frames_seen;
        s0 = dut_wins.size();
        send_range(0, NPIX - 1, 1'($urandom_range(0, 1)));
        send_range(0, NPIX - 1, 1'($urandom_range(0, 1)));
        drain();
        check("b2b_frames", 64'(frames_seen), 64'(f0 + 2));
        check("b2b_win_count", 64'(dut_wins.size() - s0), 64'(12));
        if (dut_wins.size() >= s0 + 12)
            for (int k = 0; k < 6; k++)
                check("b2b_repeat", 64'(dut_wins[s0 + 6 + k]), 64'(dut_wins[s0 + k]));

        check("frames_total", 64'(frames_seen), 64'(frames_exp));
        check("spurious_frame_done", 64'(spurious_fd), 64'(0));
        check("queue_empty", 64'(q.size()), 64'(0));
        finish_bench();
    end
endmodule
